// File: rtl/spart_mmio_bridge_pkg.sv
// Shared constants and types for the SPART memory-mapped bridge.
//   DATA_ADDR / STAT_ADDR : register addresses
//   STAT_*                : STATUS register bit positions
//   state_t               : bridge request FSM states
package spart_mmio_bridge_pkg;

   localparam int unsigned ADDR_W = 28;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned BYTE_W = 8;

   localparam logic [ADDR_W-1:0] DATA_ADDR = 28'h8000000;
   localparam logic [ADDR_W-1:0] STAT_ADDR = 28'h8000001;

   localparam int unsigned STAT_TXNF   = 0;
   localparam int unsigned STAT_RXNE   = 1;
   localparam int unsigned STAT_RXOVF  = 2;
   localparam int unsigned STAT_TXDROP = 3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_EXEC  = 2'd1,
      S_RESP  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

endpackage

// File: rtl/spart_mmio_bridge_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   i_push/i_data : write side; ignored when full unless a pop frees the slot
//   i_pop         : remove head; ignored when empty
//   o_full/o_empty/o_head : status and current head (storage resets to 0)
module spart_mmio_bridge_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic             o_full,
   output logic             o_empty,
   output logic [WIDTH-1:0] o_head
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]      r_wptr;
   logic [AW:0]      r_rptr;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_wptr == r_rptr);
   assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign o_head    = r_mem[r_rptr[AW-1:0]];
   assign w_do_pop  = i_pop && !o_empty;
   // A simultaneous pop frees the slot the push is about to write.
   assign w_do_push = i_push && (!o_full || w_do_pop);

   // Pointer and storage update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
         for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_data;
            r_wptr                <= r_wptr + (AW+1)'(1);
         end
         if (w_do_pop) r_rptr <= r_rptr + (AW+1)'(1);
      end
   end

endmodule

// File: rtl/spart_mmio_bridge.sv
// Memory-mapped slave bridging the data-side request port to the SPART core.
//   mem_*       : valid/rw/addr/ready request port, DATA and STATUS registers
//   rx_byte/rx_valid          : bytes from the receiver into the RX FIFO
//   tx_byte/tx_valid/tx_ready : TX FIFO head presented to the transmitter
module spart_mmio_bridge
   import spart_mmio_bridge_pkg::*;
#(
   parameter int unsigned       FIFO_DEPTH = 4,
   parameter logic [27:0]       DATA_ADDR  = spart_mmio_bridge_pkg::DATA_ADDR,
   parameter logic [27:0]       STAT_ADDR  = spart_mmio_bridge_pkg::STAT_ADDR
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_valid,
   input  logic        mem_rw,
   input  logic [27:0] mem_addr,
   input  logic [31:0] mem_wr_data,
   output logic [31:0] mem_rd_data,
   output logic        mem_ready,
   input  logic [7:0]  rx_byte,
   input  logic        rx_valid,
   output logic [7:0]  tx_byte,
   output logic        tx_valid,
   input  logic        tx_ready
);

   state_t              r_state, w_state_n;
   logic [ADDR_W-1:0]   r_addr, w_addr_n;
   logic                r_rw, w_rw_n;
   logic [BYTE_W-1:0]   r_wbyte, w_wbyte_n;
   logic [DATA_W-1:0]   r_rd_data, w_rd_data_n;
   logic                r_ready, w_ready_n;
   logic                r_rx_ovf, w_rx_ovf_n;
   logic                r_tx_drop, w_tx_drop_n;

   logic                w_rx_full, w_rx_empty, w_tx_full, w_tx_empty;
   logic [BYTE_W-1:0]   w_rx_head, w_tx_head;
   logic                w_exec, w_is_data, w_is_stat;
   logic                w_rx_pop, w_tx_push, w_tx_pop, w_stat_rd;
   logic                w_rx_ovf_set, w_tx_drop_set;
   logic [DATA_W-1:0]   w_status;
   logic                w_unused;

   assign w_unused = ^mem_wr_data[31:8];

   // Register operation decode on the latched request
   assign w_exec        = (r_state == S_EXEC);
   assign w_is_data     = (r_addr == DATA_ADDR);
   assign w_is_stat     = (r_addr == STAT_ADDR);
   assign w_rx_pop      = w_exec && w_is_data && !r_rw && !w_rx_empty;
   assign w_tx_push     = w_exec && w_is_data && r_rw;
   assign w_tx_pop      = tx_ready && !w_tx_empty;
   assign w_stat_rd     = w_exec && w_is_stat && !r_rw;
   assign w_rx_ovf_set  = rx_valid && w_rx_full && !w_rx_pop;
   assign w_tx_drop_set = w_tx_push && w_tx_full && !w_tx_pop;

   // STATUS word, sampled before the sticky bits are cleared
   always_comb begin
      w_status              = '0;
      w_status[STAT_TXNF]   = !w_tx_full;
      w_status[STAT_RXNE]   = !w_rx_empty;
      w_status[STAT_RXOVF]  = r_rx_ovf;
      w_status[STAT_TXDROP] = r_tx_drop;
   end

   // Next-state and registered-output logic
   always_comb begin
      w_state_n   = r_state;
      w_addr_n    = r_addr;
      w_rw_n      = r_rw;
      w_wbyte_n   = r_wbyte;
      w_rd_data_n = r_rd_data;
      w_ready_n   = 1'b0;
      w_rx_ovf_n  = r_rx_ovf;
      w_tx_drop_n = r_tx_drop;

      case (r_state)
         S_IDLE: begin
            if (mem_valid) begin
               w_addr_n  = mem_addr;
               w_rw_n    = mem_rw;
               w_wbyte_n = mem_wr_data[7:0];
               w_state_n = S_EXEC;
            end
         end
         S_EXEC: begin
            w_rd_data_n = '0;
            if (!r_rw) begin
               if (w_is_stat)                    w_rd_data_n = w_status;
               else if (w_is_data && !w_rx_empty) w_rd_data_n = {24'd0, w_rx_head};
            end
            w_ready_n = 1'b1;
            w_state_n = S_RESP;
         end
         S_RESP:  w_state_n = S_DRAIN;
         S_DRAIN: if (!mem_valid) w_state_n = S_IDLE;
         default: w_state_n = S_IDLE;
      endcase

      // Set wins over a same-cycle STATUS-read clear.
      if (w_stat_rd) begin
         w_rx_ovf_n  = 1'b0;
         w_tx_drop_n = 1'b0;
      end
      if (w_rx_ovf_set)  w_rx_ovf_n  = 1'b1;
      if (w_tx_drop_set) w_tx_drop_n = 1'b1;
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_addr    <= '0;
         r_rw      <= 1'b0;
         r_wbyte   <= '0;
         r_rd_data <= '0;
         r_ready   <= 1'b0;
         r_rx_ovf  <= 1'b0;
         r_tx_drop <= 1'b0;
      end else begin
         r_state   <= w_state_n;
         r_addr    <= w_addr_n;
         r_rw      <= w_rw_n;
         r_wbyte   <= w_wbyte_n;
         r_rd_data <= w_rd_data_n;
         r_ready   <= w_ready_n;
         r_rx_ovf  <= w_rx_ovf_n;
         r_tx_drop <= w_tx_drop_n;
      end
   end

   spart_mmio_bridge_sync_fifo #(.WIDTH(BYTE_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (rx_valid),
      .i_data  (rx_byte),
      .i_pop   (w_rx_pop),
      .o_full  (w_rx_full),
      .o_empty (w_rx_empty),
      .o_head  (w_rx_head)
   );

   spart_mmio_bridge_sync_fifo #(.WIDTH(BYTE_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_tx_push),
      .i_data  (r_wbyte),
      .i_pop   (w_tx_pop),
      .o_full  (w_tx_full),
      .o_empty (w_tx_empty),
      .o_head  (w_tx_head)
   );

   assign mem_rd_data = r_rd_data;
   assign mem_ready   = r_ready;
   assign tx_valid    = !w_tx_empty;
   assign tx_byte     = w_tx_head;

endmodule
